sd_block_responder: RTL and testbench
=====================================

Name: sd_block_responder

Overview:
- Responder end of the block-request handshake (sd_rd/sd_wr level request, sd_ack, sd_buff_addr/dout/din/wr byte port) that hps_io drives towards the core.
- Serves 512-byte blocks from a local byte-wide backing memory instead of the HPS. Used in standalone and simulation builds so save/load traffic between glue and the sdbuf dual-port RAM can run without the ARM side.
- Sits in place of hps_io's SD channel; its byte port connects to port A of sdbuf.

Parameters:
- LBA_BITS, 4, number of LBA bits used; backing store holds 2^LBA_BITS blocks.
- ACK_DELAY, 4, idle cycles between request acceptance and sd_ack rising (0..255).

Ports:
- clk_100m  input  1  core clock; all logic on rising edge.
- rst_n  input  1  asynchronous reset, active low.
- sd_lba  input  32  block number; only [LBA_BITS-1:0] used; sampled at acceptance.
- sd_rd  input  1  level request: backing store -> buffer.
- sd_wr  input  1  level request: buffer -> backing store.
- sd_ack  output  1  high for the whole transfer.
- sd_buff_addr  output  9  byte offset into the buffer.
- sd_buff_dout  output  8  byte written to the buffer.
- sd_buff_wr  output  1  buffer write strobe.
- sd_buff_din  input  8  buffer read data, valid 1 cycle after sd_buff_addr.
- mem_addr  output  LBA_BITS+9  backing-store byte address = {lba, offset}.
- mem_rdata  input  8  backing-store read data, valid 1 cycle after mem_addr.
- mem_wdata  output  8  backing-store write data.
- mem_we  output  1  backing-store write strobe.
- busy  output  1  high in any state other than IDLE.
- blocks_read  output  16  completed read transfers; wraps at 65535 -> 0.
- blocks_written  output  16  completed write transfers; wraps at 65535 -> 0.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0. Asserting rst_n low mid-transfer aborts at once: sd_ack, sd_buff_wr and mem_we drop asynchronously, and the partial block is not counted.
- States: IDLE, WAIT, RD_XFER, WR_XFER, DONE.
- IDLE: on a cycle with sd_wr=1 or sd_rd=1:
  - latch sd_lba[LBA_BITS-1:0] and the direction; sd_wr wins if both are high.
  - go to WAIT with a delay counter of ACK_DELAY; if ACK_DELAY=0, go straight to the transfer state.
- WAIT: decrement the counter; at 0 enter RD_XFER or WR_XFER. Requests are ignored.
- sd_ack is registered. It is 1 in every cycle in RD_XFER, WR_XFER and DONE, and 0 elsewhere.
- RD_XFER, byte counter i = 0..511, one byte per cycle:
  - cycle t: mem_addr = {lba, i}.
  - cycle t+1: sd_buff_addr = i, sd_buff_dout = mem_rdata, sd_buff_wr = 1.
  - Result: exactly 512 consecutive sd_buff_wr pulses, addresses 0..511 ascending.
  - After the last strobe, go to DONE.
- WR_XFER, byte counter i = 0..511:
  - cycle t: sd_buff_addr = i.
  - cycle t+1: mem_addr = {lba, i}, mem_wdata = sd_buff_din, mem_we = 1.
  - Result: exactly 512 consecutive mem_we pulses, addresses ascending.
  - After the last strobe, go to DONE.
- Strobes never occur outside the transfer states. sd_buff_wr is never high in WR_XFER; mem_we is never high in RD_XFER.
- Byte counter is 10 bits; the transfer ends when it reaches 512; offsets use bits [8:0].
- DONE: lasts one cycle.
  - Increment blocks_read or blocks_written.
  - Deassert sd_ack on the next edge.
  - Return to IDLE only once sd_rd=0 and sd_wr=0; otherwise stay in DONE with sd_ack low. This blocks retriggering from a held level.
- Requests that arrive or change in WAIT, RD_XFER or WR_XFER are ignored. The requester clears its request on seeing sd_ack.
- busy = (state != IDLE).

Test Plan:
- Reset values: hold rst_n=0 with sd_rd=1 -> sd_ack, busy, strobes and counters all 0; release -> request accepted next edge, sd_ack rises 5 cycles later with ACK_DELAY=4.
- Read block: preload mem[{3,i}] = i^8'hA5, sd_lba=3, pulse sd_rd until ack -> 512 sd_buff_wr pulses, addr 0..511, dout = i^A5 each; sd_ack high 513 cycles; blocks_read=1.
- Write block: buffer model holds byte i = 255-i, sd_lba=7, sd_wr -> mem[{7,i}] = 255-i for all i; no sd_buff_wr pulses; blocks_written=1.
- Simultaneous request: sd_rd=sd_wr=1 in one cycle -> write performed; sd_rd held high after completion -> stays in DONE, no second transfer until both requests are low.
- Mid-transfer reset: assert rst_n low at byte 200 of a read -> sd_ack and sd_buff_wr go 0 immediately, blocks_read stays 0; a new request then completes a full 512-byte transfer.
- LBA truncation and wrap: sd_lba=32'h0000_0013, LBA_BITS=4 -> mem_addr uses block 3; force blocks_written=65535, then do one write -> blocks_written=0.

Source files
------------

// File: rtl/sd_block_responder.sv
// Block-request responder: serves 512-byte sd_rd/sd_wr transfers from a local
// byte-wide backing store, standing in for the HPS SD channel of hps_io.
module sd_block_responder #(
  parameter int unsigned LBA_BITS  = 4,
  parameter int unsigned ACK_DELAY = 4
) (
  input  logic                  clk_100m,
  input  logic                  rst_n,
  input  logic [31:0]           sd_lba,
  input  logic                  sd_rd,
  input  logic                  sd_wr,
  output logic                  sd_ack,
  output logic [8:0]            sd_buff_addr,
  output logic [7:0]            sd_buff_dout,
  output logic                  sd_buff_wr,
  input  logic [7:0]            sd_buff_din,
  output logic [LBA_BITS+8:0]   mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  busy,
  output logic [15:0]           blocks_read,
  output logic [15:0]           blocks_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD_XFER,
    S_WR_XFER,
    S_DONE
  } state_t;

  localparam logic [7:0] DLY_INIT = 8'(ACK_DELAY);

  state_t              r_state;
  state_t              w_next;
  logic [LBA_BITS-1:0] r_lba;
  logic [LBA_BITS-1:0] w_lba;
  logic                r_dir_wr;
  logic [7:0]          r_dly;
  logic [9:0]          r_cnt;
  logic [9:0]          w_cnt_inc;
  logic [8:0]          w_pre_off;
  logic                w_req;
  logic                r_ack;
  logic [15:0]         r_blocks_rd;
  logic [15:0]         r_blocks_wr;
  logic                w_unused_lba;

  assign w_req        = sd_rd | sd_wr;
  assign w_cnt_inc    = r_cnt + 10'd1;
  assign w_unused_lba = ^sd_lba[31:LBA_BITS];

  // The source side of each transfer runs one offset ahead of the strobe side,
  // so offset 0 is fetched in the cycle before the transfer state and all 512
  // strobes land inside RD_XFER/WR_XFER.
  always_comb begin
    w_pre_off = '0;
    if (r_state == S_RD_XFER || r_state == S_WR_XFER) w_pre_off = w_cnt_inc[8:0];
    w_lba = r_lba;
    if (ACK_DELAY == 0 && r_state == S_IDLE) w_lba = sd_lba[LBA_BITS-1:0];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (w_req) begin
          if (ACK_DELAY == 0) w_next = sd_wr ? S_WR_XFER : S_RD_XFER;
          else                w_next = S_WAIT;
        end
      S_WAIT:
        if (r_dly == '0) w_next = r_dir_wr ? S_WR_XFER : S_RD_XFER;
      S_RD_XFER, S_WR_XFER:
        if (w_cnt_inc == 10'd512) w_next = S_DONE;
      S_DONE:
        if (!w_req) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    sd_buff_wr   = 1'b0;
    sd_buff_addr = '0;
    sd_buff_dout = '0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    mem_addr     = {w_lba, w_pre_off};
    case (r_state)
      S_RD_XFER: begin
        sd_buff_wr   = 1'b1;
        sd_buff_addr = r_cnt[8:0];
        sd_buff_dout = mem_rdata;
      end
      S_WR_XFER: begin
        sd_buff_addr = w_pre_off;
        mem_we       = 1'b1;
        mem_wdata    = sd_buff_din;
        mem_addr     = {r_lba, r_cnt[8:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lba       <= '0;
      r_dir_wr    <= 1'b0;
      r_dly       <= '0;
      r_cnt       <= '0;
      r_ack       <= 1'b0;
      r_blocks_rd <= '0;
      r_blocks_wr <= '0;
    end else begin
      r_state <= w_next;
      // Ack stays high only for the first DONE cycle; a held request keeps DONE with ack low.
      r_ack   <= (w_next == S_RD_XFER) || (w_next == S_WR_XFER) ||
                 (w_next == S_DONE && r_state != S_DONE);
      case (r_state)
        S_IDLE:
          if (w_req) begin
            r_lba    <= sd_lba[LBA_BITS-1:0];
            r_dir_wr <= sd_wr;
            r_dly    <= DLY_INIT;
            r_cnt    <= '0;
          end
        S_WAIT:
          if (r_dly != '0) r_dly <= r_dly - 8'd1;
        S_RD_XFER, S_WR_XFER:
          r_cnt <= w_cnt_inc;
        default: ;
      endcase
      if (r_state == S_RD_XFER && w_next == S_DONE) r_blocks_rd <= r_blocks_rd + 16'd1;
      if (r_state == S_WR_XFER && w_next == S_DONE) r_blocks_wr <= r_blocks_wr + 16'd1;
    end
  end

  assign sd_ack         = r_ack;
  assign busy           = (r_state != S_IDLE);
  assign blocks_read    = r_blocks_rd;
  assign blocks_written = r_blocks_wr;

endmodule

// File: tb/tb_sd_block_responder.sv
// Bench for sd_block_responder: directed and random block traffic checked
// against a block-level model of the backing store and sdbuf contents.
`timescale 1ns/1ps
module tb_sd_block_responder;
  localparam int unsigned LB    = 4;
  localparam int unsigned DLY   = 4;
  localparam int unsigned MEMSZ = 1 << (LB + 9);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   sd_lba = '0;
  logic          sd_rd = 1'b0;
  logic          sd_wr = 1'b0;
  logic          sd_ack;
  logic [8:0]    sd_buff_addr;
  logic [7:0]    sd_buff_dout;
  logic          sd_buff_wr;
  logic [7:0]    sd_buff_din;
  logic [LB+8:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic          busy;
  logic [15:0]   blocks_read;
  logic [15:0]   blocks_written;

  always #5 clk = ~clk;

  sd_block_responder #(.LBA_BITS(LB), .ACK_DELAY(DLY)) dut (
    .clk_100m(clk), .rst_n(rst_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy),
    .blocks_read(blocks_read), .blocks_written(blocks_written)
  );

  // Environment: backing store and sdbuf port A, both with one-cycle read latency.
  logic [7:0] mem       [MEMSZ];
  logic [7:0] bufm      [512];
  logic [7:0] stage_mem [MEMSZ];
  logic [7:0] stage_buf [512];
  logic       load_m = 1'b0;
  logic       load_b = 1'b0;

  always @(posedge clk) begin
    mem_rdata   <= mem[mem_addr];
    sd_buff_din <= bufm[sd_buff_addr];
    if (load_m)      mem <= stage_mem;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (load_b)          bufm <= stage_buf;
    else if (sd_buff_wr) bufm[sd_buff_addr] <= sd_buff_dout;
  end

  // Strobe monitor
  int unsigned q_bw_a[$], q_bw_d[$], q_we_a[$], q_we_d[$];
  int unsigned ack_total = 0;
  int unsigned n_viol = 0;
  always @(negedge clk) begin
    if (sd_buff_wr) begin q_bw_a.push_back(sd_buff_addr); q_bw_d.push_back(sd_buff_dout); end
    if (mem_we)     begin q_we_a.push_back(mem_addr);     q_we_d.push_back(mem_wdata);    end
    if (sd_ack) ack_total++;
    if ((sd_buff_wr && mem_we) || ((sd_buff_wr || mem_we) && !sd_ack)) n_viol++;
  end

  // Reference model
  logic [7:0]  ref_mem [MEMSZ];
  logic [7:0]  exp_buf [512];
  logic [15:0] exp_nrd = '0;
  logic [15:0] exp_nwr = '0;
  int unsigned bw_base, we_base, ack_base;
  int unsigned n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic snap();
    bw_base  = q_bw_a.size();
    we_base  = q_we_a.size();
    ack_base = ack_total;
  endtask

  task automatic load_mem_random();
    for (int i = 0; i < int'(MEMSZ); i++) stage_mem[i] = 8'($urandom);
  endtask

  task automatic push_mem();
    @(negedge clk); load_m = 1'b1;
    @(negedge clk); load_m = 1'b0;
    ref_mem = stage_mem;
  endtask

  task automatic push_buf();
    @(negedge clk); load_b = 1'b1;
    @(negedge clk); load_b = 1'b0;
    exp_buf = stage_buf;
  endtask

  task automatic wait_ack();
    int n = 0;
    while (!sd_ack && n < 100) begin @(negedge clk); n++; end
    chk("ack_seen", 32'(sd_ack), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin @(negedge clk); n++; end
    chk("idle", 32'(busy), 32'd0);
  endtask

  task automatic check_xfer(input bit wr, input logic [31:0] lba);
    int unsigned base, bad, nbw, nwe;
    logic [LB-1:0] l;
    l    = lba[LB-1:0];
    base = int'(l) << 9;
    bad  = 0;
    nbw  = q_bw_a.size() - bw_base;
    nwe  = q_we_a.size() - we_base;
    if (!wr) begin
      chk("rd_strobes", nbw, 512);
      chk("rd_no_memwe", nwe, 0);
      for (int i = 0; i < 512; i++) begin
        if (i < int'(nbw) && (q_bw_a[bw_base+i] != i || q_bw_d[bw_base+i] != ref_mem[base+i])) bad++;
        exp_buf[i] = ref_mem[base+i];
      end
      chk("rd_stream", bad, 0);
      exp_nrd = exp_nrd + 16'd1;
    end else begin
      chk("wr_strobes", nwe, 512);
      chk("wr_no_buffwr", nbw, 0);
      for (int i = 0; i < 512; i++) begin
        if (i < int'(nwe) && (q_we_a[we_base+i] != base + i || q_we_d[we_base+i] != exp_buf[i])) bad++;
        ref_mem[base+i] = exp_buf[i];
      end
      chk("wr_stream", bad, 0);
      exp_nwr = exp_nwr + 16'd1;
    end
    chk("ack_cycles", ack_total - ack_base, 513);
    bad = 0;
    for (int i = 0; i < int'(MEMSZ); i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", bad, 0);
    bad = 0;
    for (int i = 0; i < 512; i++) if (bufm[i] !== exp_buf[i]) bad++;
    chk("buf_image", bad, 0);
    chk("blocks_read", 32'(blocks_read), 32'(exp_nrd));
    chk("blocks_written", 32'(blocks_written), 32'(exp_nwr));
  endtask

  task automatic do_xfer(input bit wr, input logic [31:0] lba);
    @(negedge clk);
    snap();
    sd_lba = lba; sd_wr = wr; sd_rd = !wr;
    wait_ack();
    sd_rd = 1'b0; sd_wr = 1'b0;
    wait_idle();
    @(negedge clk);
    check_xfer(wr, lba);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    logic [31:0] lba;
    bit          wr;

    // Reset with a read pending; block 3 holds i^A5
    load_mem_random();
    for (int i = 0; i < 512; i++) stage_mem[(3 << 9) + i] = 8'(i) ^ 8'hA5;
    for (int i = 0; i < 512; i++) stage_buf[i] = 8'($urandom);
    sd_lba = 32'd3; sd_rd = 1'b1;
    push_mem();
    push_buf();
    @(negedge clk);
    chk("rst_ack", 32'(sd_ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_buffwr", 32'(sd_buff_wr), 0);
    chk("rst_memwe", 32'(mem_we), 0);
    chk("rst_memaddr", 32'(mem_addr), 0);
    chk("rst_nrd", 32'(blocks_read), 0);
    chk("rst_nwr", 32'(blocks_written), 0);
    snap();
    rst_n = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; if (n == 1) chk("accept_busy", 32'(busy), 1); end
    while (!sd_ack && n < 50);
    chk("ack_latency", n, 6);
    sd_rd = 1'b0;
    wait_idle();
    @(negedge clk);
    check_xfer(1'b0, 32'd3);

    // Write block 7 from a buffer holding 255-i
    for (int i = 0; i < 512; i++) stage_buf[i] = 8'(255 - i);
    push_buf();
    do_xfer(1'b1, 32'd7);

    // Simultaneous request: write wins; held sd_rd parks in DONE
    for (int i = 0; i < 512; i++) stage_buf[i] = 8'($urandom);
    push_buf();
    lba = $urandom;
    @(negedge clk);
    snap();
    sd_lba = lba; sd_rd = 1'b1; sd_wr = 1'b1;
    @(negedge clk);
    sd_wr = 1'b0;
    wait_ack();
    n = 0;
    while (sd_ack && n < 700) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    chk("held_busy", 32'(busy), 1);
    chk("held_ack", 32'(sd_ack), 0);
    check_xfer(1'b1, lba);
    sd_rd = 1'b0;
    @(negedge clk);
    chk("release_idle", 32'(busy), 0);
    repeat (20) @(negedge clk);
    chk("no_retrigger", q_bw_a.size() - bw_base, 0);
    chk("no_retrigger_nrd", 32'(blocks_read), 32'(exp_nrd));

    // Reset during byte 200 of a read
    @(negedge clk);
    snap();
    sd_lba = 32'd5; sd_rd = 1'b1;
    wait_ack();
    sd_rd = 1'b0;
    n = 0;
    while (!(sd_buff_wr && sd_buff_addr == 9'd200) && n < 600) begin @(negedge clk); n++; end
    chk("reached_byte200", 32'(sd_buff_addr), 200);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ack", 32'(sd_ack), 0);
    chk("abort_buffwr", 32'(sd_buff_wr), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_nrd", 32'(blocks_read), 0);
    for (int i = 0; i < 200; i++) exp_buf[i] = ref_mem[(5 << 9) + i];
    exp_nrd = '0; exp_nwr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_xfer(1'b0, 32'd5);

    // LBA truncation and blocks_written wrap
    @(negedge clk);
    force dut.r_blocks_wr = 16'hFFFF;
    @(negedge clk);
    release dut.r_blocks_wr;
    exp_nwr = 16'hFFFF;
    chk("forced_nwr", 32'(blocks_written), 32'hFFFF);
    for (int i = 0; i < 512; i++) stage_buf[i] = 8'($urandom);
    push_buf();
    do_xfer(1'b1, 32'h0000_0013);

    // Random traffic
    for (int k = 0; k < 8; k++) begin
      wr  = 1'($urandom_range(0, 1));
      lba = $urandom;
      if (wr) begin
        for (int i = 0; i < 512; i++) stage_buf[i] = 8'($urandom);
        push_buf();
      end
      do_xfer(wr, lba);
    end

    chk("strobe_outside_ack", n_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
